// File: rtl/tile_core_if_mt.sv
// tile_core_if_mt: round-robin arbiter from NUM_THREADS core request channels onto one L1.5 channel.
// Optional per-thread watchdog is built when TILE_CORE_IF_MT_TIMEOUT_EN is defined.
`ifndef L15_AMO_OP_WIDTH
`define L15_AMO_OP_WIDTH 4
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif

module tile_core_if_mt #(
    parameter int NUM_THREADS    = 2,
    parameter int TID_WIDTH      = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_THREADS-1:0]                        core_req_val,
    output logic [NUM_THREADS-1:0]                        core_req_rdy,
    input  logic [5*NUM_THREADS-1:0]                      core_req_rqtype,
    input  logic [`L15_AMO_OP_WIDTH*NUM_THREADS-1:0]      core_req_amo_op,
    input  logic [3*NUM_THREADS-1:0]                      core_req_size,
    input  logic [`PHY_ADDR_WIDTH*NUM_THREADS-1:0]        core_req_addr,
    input  logic [64*NUM_THREADS-1:0]                     core_req_data,
    input  logic [NUM_THREADS-1:0]                        core_req_nc,
    output logic                                          transducer_l15_val,
    output logic [4:0]                                    transducer_l15_rqtype,
    output logic [`L15_AMO_OP_WIDTH-1:0]                  transducer_l15_amo_op,
    output logic [2:0]                                    transducer_l15_size,
    output logic [`PHY_ADDR_WIDTH-1:0]                    transducer_l15_address,
    output logic [63:0]                                   transducer_l15_data,
    output logic                                          transducer_l15_nc,
    output logic [TID_WIDTH-1:0]                          transducer_l15_threadid,
    output logic                                          transducer_l15_prefetch,
    output logic                                          transducer_l15_invalidate_cacheline,
    output logic                                          transducer_l15_blockstore,
    output logic                                          transducer_l15_blockinitstore,
    output logic [1:0]                                    transducer_l15_l1rplway,
    output logic [63:0]                                   transducer_l15_data_next_entry,
    output logic [32:0]                                   transducer_l15_csm_data,
    input  logic                                          l15_transducer_ack,
    input  logic                                          l15_transducer_header_ack,
    input  logic                                          l15_transducer_val,
    input  logic [3:0]                                    l15_transducer_returntype,
    input  logic [TID_WIDTH-1:0]                          l15_transducer_threadid,
    input  logic [63:0]                                   l15_transducer_data_0,
    input  logic [63:0]                                   l15_transducer_data_1,
    output logic                                          transducer_l15_req_ack,
    output logic [NUM_THREADS-1:0]                        core_rsp_val,
    output logic [3:0]                                    core_rsp_returntype,
    output logic [63:0]                                   core_rsp_data_0,
    output logic [63:0]                                   core_rsp_data_1,
    output logic                                          stray_rsp_err,
    output logic [NUM_THREADS-1:0]                        timeout_err
);
    localparam int AW = `PHY_ADDR_WIDTH;
    localparam int OW = `L15_AMO_OP_WIDTH;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                   r_state;
    state_t                   w_nextState;
    logic [NUM_THREADS-1:0]   r_outstanding;
    logic [TID_WIDTH-1:0]     r_rrPtr;
    logic [TID_WIDTH-1:0]     r_grant;
    logic [4:0]               r_rqtype;
    logic [OW-1:0]            r_amoOp;
    logic [2:0]               r_size;
    logic [AW-1:0]            r_addr;
    logic [63:0]              r_data;
    logic                     r_nc;
    logic [NUM_THREADS-1:0]   r_rspVal;
    logic [3:0]               r_rspType;
    logic [63:0]              r_rspData0;
    logic [63:0]              r_rspData1;
    logic                     r_strayErr;

    logic [NUM_THREADS-1:0]   w_eligible;
    logic [2*NUM_THREADS-1:0] w_dblElig;
    logic [NUM_THREADS-1:0]   w_rotElig;
    logic                     w_found;
    logic [TID_WIDTH-1:0]     w_pick;
    logic                     w_ackFire;
    logic [NUM_THREADS-1:0]   w_setMask;
    logic [NUM_THREADS-1:0]   w_tidMask;
    logic                     w_rspHit;
    logic                     w_unused;

    assign w_eligible = core_req_val & ~r_outstanding;
    assign w_dblElig  = {w_eligible, w_eligible};
    assign w_rotElig  = NUM_THREADS'(w_dblElig >> r_rrPtr);

    // Lowest set bit of the rotated vector is the first eligible thread at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (w_rotElig[i]) begin
                w_found = 1'b1;
                w_pick  = TID_WIDTH'((int'(r_rrPtr) + i) % NUM_THREADS);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ackFire   = 1'b0;
        case (r_state)
            IDLE:    if (w_found) w_nextState = ISSUE;
            ISSUE: begin
                if (l15_transducer_ack) begin
                    w_ackFire   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_setMask = '0;
        w_tidMask = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_setMask[t] = w_ackFire && (int'(r_grant) == t);
            w_tidMask[t] = (int'(l15_transducer_threadid) == t);
        end
    end

    // A response racing the ack of its own thread sees outstanding=0 and is classed stray.
    assign w_rspHit = l15_transducer_val && (|(w_tidMask & r_outstanding & ~w_setMask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_outstanding <= '0;
            r_rrPtr       <= '0;
            r_grant       <= '0;
            r_rqtype      <= '0;
            r_amoOp       <= '0;
            r_size        <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_nc          <= 1'b0;
            r_rspVal      <= '0;
            r_rspType     <= '0;
            r_rspData0    <= '0;
            r_rspData1    <= '0;
            r_strayErr    <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_outstanding <= (r_outstanding & ~(w_rspHit ? w_tidMask : '0)) | w_setMask;
            if (r_state == IDLE && w_found) begin
                r_grant  <= w_pick;
                r_rrPtr  <= TID_WIDTH'((int'(w_pick) + 1) % NUM_THREADS);
                r_rqtype <= core_req_rqtype[int'(w_pick)*5 +: 5];
                r_amoOp  <= core_req_amo_op[int'(w_pick)*OW +: OW];
                r_size   <= core_req_size[int'(w_pick)*3 +: 3];
                r_addr   <= core_req_addr[int'(w_pick)*AW +: AW];
                r_data   <= core_req_data[int'(w_pick)*64 +: 64];
                r_nc     <= core_req_nc[w_pick];
            end
            r_rspVal <= w_rspHit ? w_tidMask : '0;
            if (w_rspHit) begin
                r_rspType  <= l15_transducer_returntype;
                r_rspData0 <= l15_transducer_data_0;
                r_rspData1 <= l15_transducer_data_1;
            end
            if (l15_transducer_val && !w_rspHit) r_strayErr <= 1'b1;
        end
    end

`ifdef TILE_CORE_IF_MT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]          r_wdCount [NUM_THREADS];
    logic [NUM_THREADS-1:0] r_timeoutErr;

    // Counter saturates at the limit; the flag is sticky and does not release the thread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) r_wdCount[t] <= '0;
            r_timeoutErr <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (w_setMask[t]) begin
                    r_wdCount[t] <= '0;
                end else if (r_outstanding[t] && r_wdCount[t] != CW'(TIMEOUT_CYCLES)) begin
                    r_wdCount[t] <= r_wdCount[t] + 1'b1;
                    if (r_wdCount[t] == CW'(TIMEOUT_CYCLES - 1)) r_timeoutErr[t] <= 1'b1;
                end
            end
        end
    end

    assign timeout_err = r_timeoutErr;
    assign w_unused    = l15_transducer_header_ack;
`else
    assign timeout_err = '0;
    assign w_unused    = l15_transducer_header_ack ^ (TIMEOUT_CYCLES == 0);
`endif

    assign transducer_l15_val                  = (r_state == ISSUE);
    assign transducer_l15_rqtype               = r_rqtype;
    assign transducer_l15_amo_op               = r_amoOp;
    assign transducer_l15_size                 = r_size;
    assign transducer_l15_address              = r_addr;
    assign transducer_l15_data                 = r_data;
    assign transducer_l15_nc                   = r_nc;
    assign transducer_l15_threadid             = r_grant;
    assign transducer_l15_prefetch             = 1'b0;
    assign transducer_l15_invalidate_cacheline = 1'b0;
    assign transducer_l15_blockstore           = 1'b0;
    assign transducer_l15_blockinitstore       = 1'b0;
    assign transducer_l15_l1rplway             = 2'b00;
    assign transducer_l15_data_next_entry      = 64'd0;
    assign transducer_l15_csm_data             = 33'd0;
    assign transducer_l15_req_ack              = l15_transducer_val;
    assign core_req_rdy                        = w_setMask;
    assign core_rsp_val                        = r_rspVal;
    assign core_rsp_returntype                 = r_rspType;
    assign core_rsp_data_0                     = r_rspData0;
    assign core_rsp_data_1                     = r_rspData1;
    assign stray_rsp_err                       = r_strayErr;

endmodule

// File: tb/tb_tile_core_if_mt.sv
// tb_tile_core_if_mt: directed bench for tile_core_if_mt with a per-cycle behavioural model check.
`ifndef L15_AMO_OP_WIDTH
`define L15_AMO_OP_WIDTH 4
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif

module tb_tile_core_if_mt;
    localparam int N  = 2;
    localparam int TW = 1;
    localparam int AW = `PHY_ADDR_WIDTH;
    localparam int OW = `L15_AMO_OP_WIDTH;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    coreReqVal;
    logic [N-1:0]    core_req_rdy;
    logic [5*N-1:0]  coreReqRqtype;
    logic [OW*N-1:0] coreReqAmoOp;
    logic [3*N-1:0]  coreReqSize;
    logic [AW*N-1:0] coreReqAddr;
    logic [64*N-1:0] coreReqData;
    logic [N-1:0]    coreReqNc;
    logic            transducer_l15_val;
    logic [4:0]      transducer_l15_rqtype;
    logic [OW-1:0]   transducer_l15_amo_op;
    logic [2:0]      transducer_l15_size;
    logic [AW-1:0]   transducer_l15_address;
    logic [63:0]     transducer_l15_data;
    logic            transducer_l15_nc;
    logic [TW-1:0]   transducer_l15_threadid;
    logic            prefetch, invCl, blockStore, blockInitStore;
    logic [1:0]      l1rplway;
    logic [63:0]     dataNextEntry;
    logic [32:0]     csmData;
    logic            l15Ack, l15HeaderAck, l15Val;
    logic [3:0]      l15Rtype;
    logic [TW-1:0]   l15Tid;
    logic [63:0]     l15Data0, l15Data1;
    logic            transducer_l15_req_ack;
    logic [N-1:0]    core_rsp_val;
    logic [3:0]      core_rsp_returntype;
    logic [63:0]     core_rsp_data_0, core_rsp_data_1;
    logic            stray_rsp_err;
    logic [N-1:0]    timeout_err;

    int checkCount = 0;
    int errorCount = 0;

    tile_core_if_mt #(.NUM_THREADS(N), .TID_WIDTH(TW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_val(coreReqVal), .core_req_rdy(core_req_rdy),
        .core_req_rqtype(coreReqRqtype), .core_req_amo_op(coreReqAmoOp),
        .core_req_size(coreReqSize), .core_req_addr(coreReqAddr),
        .core_req_data(coreReqData), .core_req_nc(coreReqNc),
        .transducer_l15_val(transducer_l15_val), .transducer_l15_rqtype(transducer_l15_rqtype),
        .transducer_l15_amo_op(transducer_l15_amo_op), .transducer_l15_size(transducer_l15_size),
        .transducer_l15_address(transducer_l15_address), .transducer_l15_data(transducer_l15_data),
        .transducer_l15_nc(transducer_l15_nc), .transducer_l15_threadid(transducer_l15_threadid),
        .transducer_l15_prefetch(prefetch), .transducer_l15_invalidate_cacheline(invCl),
        .transducer_l15_blockstore(blockStore), .transducer_l15_blockinitstore(blockInitStore),
        .transducer_l15_l1rplway(l1rplway), .transducer_l15_data_next_entry(dataNextEntry),
        .transducer_l15_csm_data(csmData),
        .l15_transducer_ack(l15Ack), .l15_transducer_header_ack(l15HeaderAck),
        .l15_transducer_val(l15Val), .l15_transducer_returntype(l15Rtype),
        .l15_transducer_threadid(l15Tid), .l15_transducer_data_0(l15Data0),
        .l15_transducer_data_1(l15Data1), .transducer_l15_req_ack(transducer_l15_req_ack),
        .core_rsp_val(core_rsp_val), .core_rsp_returntype(core_rsp_returntype),
        .core_rsp_data_0(core_rsp_data_0), .core_rsp_data_1(core_rsp_data_1),
        .stray_rsp_err(stray_rsp_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int t, input logic val, input logic [4:0] rqtype,
                                 input logic [OW-1:0] amo, input logic [2:0] size,
                                 input logic [AW-1:0] addr, input logic [63:0] data, input logic nc);
        coreReqVal[t]              = val;
        coreReqRqtype[t*5 +: 5]    = rqtype;
        coreReqAmoOp[t*OW +: OW]   = amo;
        coreReqSize[t*3 +: 3]      = size;
        coreReqAddr[t*AW +: AW]    = addr;
        coreReqData[t*64 +: 64]    = data;
        coreReqNc[t]               = nc;
    endtask

    task automatic sendResponse(input int t, input logic [3:0] rtype, input logic [63:0] d0, input logic [63:0] d1);
        l15Val = 1'b1;
        l15Tid = TW'(t);
        l15Rtype = rtype;
        l15Data0 = d0;
        l15Data1 = d1;
        tick(1);
        l15Val = 1'b0;
    endtask

    // Waits (bounded) for a request on the L1.5 channel, acks it for one cycle.
    task automatic issueAndAck(output int tid, output logic [N-1:0] rdy);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (transducer_l15_val) seen = 1'b1;
            else tick(1);
        end
        if (!seen) checkOutput("issue_wait_expired", 1'b0, 1'b1);
        l15Ack = 1'b1;
        #1;
        tid = int'(transducer_l15_threadid);
        rdy = core_req_rdy;
        tick(1);
        l15Ack = 1'b0;
    endtask

    // Behavioural model: one pending request slot, per-thread busy flags, rotating priority.
    logic [N-1:0]  mOut, nOut;
    int            mLast, mGrant;
    bit            mBusy, mPend, nPend, mStray, hit, found;
    int            mPendTid;
    logic [3:0]    mPendType;
    logic [63:0]   mPendD0, mPendD1;
    logic [4:0]    sRqtype;
    logic [OW-1:0] sAmo;
    logic [2:0]    sSize;
    logic [AW-1:0] sAddr;
    logic [63:0]   sData;
    logic          sNc;

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("req_ack_follows_val", transducer_l15_req_ack, l15Val);
            checkOutput("const_outputs", {prefetch, invCl, blockStore, blockInitStore, l1rplway, dataNextEntry, csmData}, '0);
`ifndef TILE_CORE_IF_MT_TIMEOUT_EN
            checkOutput("timeout_off", timeout_err, '0);
`endif
            if (!rst_n) begin
                checkOutput("rst_l15_val", transducer_l15_val, 1'b0);
                checkOutput("rst_rdy", core_req_rdy, '0);
                checkOutput("rst_rsp_val", core_rsp_val, '0);
                checkOutput("rst_stray", stray_rsp_err, 1'b0);
                checkOutput("rst_fields", {transducer_l15_address, transducer_l15_data, core_rsp_data_0}, '0);
                mOut = '0; mLast = N - 1; mBusy = 0; mPend = 0; mStray = 0; mGrant = 0;
            end else begin
                checkOutput("m_l15_val", transducer_l15_val, mBusy);
                if (mBusy) begin
                    checkOutput("m_threadid", transducer_l15_threadid, mGrant);
                    checkOutput("m_req_fields", {transducer_l15_rqtype, transducer_l15_amo_op, transducer_l15_size,
                                                 transducer_l15_address, transducer_l15_nc},
                                                {sRqtype, sAmo, sSize, sAddr, sNc});
                    checkOutput("m_req_data", transducer_l15_data, sData);
                end
                checkOutput("m_rdy", core_req_rdy, (mBusy && l15Ack) ? (N'(1) << mGrant) : '0);
                checkOutput("m_rsp_val", core_rsp_val, mPend ? (N'(1) << mPendTid) : '0);
                if (mPend) begin
                    checkOutput("m_rsp_type", core_rsp_returntype, mPendType);
                    checkOutput("m_rsp_data", {core_rsp_data_0, core_rsp_data_1}, {mPendD0, mPendD1});
                end
                checkOutput("m_stray", stray_rsp_err, mStray);

                nOut = mOut;
                nPend = 0;
                if (l15Val) begin
                    hit = (int'(l15Tid) < N) && mOut[l15Tid] && !(mBusy && l15Ack && mGrant == int'(l15Tid));
                    if (hit) begin
                        nOut[l15Tid] = 1'b0;
                        nPend = 1;
                        mPendTid = int'(l15Tid);
                        mPendType = l15Rtype;
                        mPendD0 = l15Data0;
                        mPendD1 = l15Data1;
                    end else begin
                        mStray = 1;
                    end
                end
                if (mBusy && l15Ack) begin
                    nOut[mGrant] = 1'b1;
                    mBusy = 0;
                    mLast = mGrant;
                end else if (!mBusy) begin
                    found = 0;
                    for (int i = 1; i <= N; i++) begin
                        int k;
                        k = (mLast + i) % N;
                        if (!found && coreReqVal[k] && !mOut[k]) begin
                            found = 1;
                            mBusy = 1;
                            mGrant = k;
                            sRqtype = coreReqRqtype[k*5 +: 5];
                            sAmo = coreReqAmoOp[k*OW +: OW];
                            sSize = coreReqSize[k*3 +: 3];
                            sAddr = coreReqAddr[k*AW +: AW];
                            sData = coreReqData[k*64 +: 64];
                            sNc = coreReqNc[k];
                        end
                    end
                end
                mOut = nOut;
                mPend = nPend;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: simulation did not complete");
        $fatal(1, "[TB] time limit");
    end

    int            tid, valCycles;
    logic [N-1:0]  rdy;
    logic [AW-1:0] addrSeen;
    logic [N-1:0]  expTo;
    int            order [4];

    initial begin
        rst_n = 1'b0;
        coreReqVal = '0; coreReqRqtype = '0; coreReqAmoOp = '0; coreReqSize = '0;
        coreReqAddr = '0; coreReqData = '0; coreReqNc = '0;
        l15Ack = 0; l15HeaderAck = 0; l15Val = 0; l15Rtype = '0; l15Tid = '0; l15Data0 = '0; l15Data1 = '0;
        tick(3);
        checkOutput("reset_l15_val", transducer_l15_val, 1'b0);
        checkOutput("reset_stray", stray_rsp_err, 1'b0);
        rst_n = 1'b1;
        tick(1);

        // Thread 0 request held three cycles before ack.
        applyStimulus(0, 1'b1, 5'h01, 4'h0, 3'd3, 40'h40, 64'h1111_2222_3333_4444, 1'b0);
        tick(1);
        valCycles = 0;
        for (int c = 0; c < 3; c++) begin
            if (transducer_l15_val) valCycles++;
            if (c == 2) begin
                l15Ack = 1'b1;
                #1;
                rdy = core_req_rdy;
                tid = int'(transducer_l15_threadid);
                addrSeen = transducer_l15_address;
            end
            tick(1);
        end
        l15Ack = 1'b0;
        coreReqVal[0] = 1'b0;
        checkOutput("t040_val_cycles", valCycles, 3);
        checkOutput("t040_rdy", rdy, 2'b01);
        checkOutput("t040_tid", tid, 0);
        checkOutput("t040_addr", addrSeen, 40'h40);
        checkOutput("t040_val_drop", transducer_l15_val, 1'b0);
        sendResponse(0, 4'h1, 64'hAAAA, 64'hBBBB);
        checkOutput("t040_rsp_val", core_rsp_val, 2'b01);
        checkOutput("t040_rsp_data1", core_rsp_data_1, 64'hBBBB);

        // Thread 1 response carries 0xDEAD and frees the thread.
        applyStimulus(1, 1'b1, 5'h02, 4'h3, 3'd2, 40'h80, 64'h5555, 1'b1);
        issueAndAck(tid, rdy);
        coreReqVal[1] = 1'b0;
        checkOutput("t042_tid", tid, 1);
        checkOutput("t042_rdy", rdy, 2'b10);
        sendResponse(1, 4'h2, 64'hDEAD, 64'h0);
        checkOutput("t042_rsp_val", core_rsp_val, 2'b10);
        checkOutput("t042_rsp_data0", core_rsp_data_0, 64'hDEAD);

        // Thread 1 re-granted after its response; dropping valid mid-issue keeps the request.
        applyStimulus(1, 1'b1, 5'h04, 4'h1, 3'd1, 40'hC0, 64'h7777, 1'b0);
        tick(2);
        coreReqVal[1] = 1'b0;
        tick(2);
        checkOutput("t019_val_held", transducer_l15_val, 1'b1);
        issueAndAck(tid, rdy);
        checkOutput("t019_tid", tid, 1);
        checkOutput("t019_rdy", rdy, 2'b10);
        sendResponse(1, 4'h3, 64'h1, 64'h2);
        checkOutput("t019_rsp_val", core_rsp_val, 2'b10);

        // Response for a thread with nothing outstanding.
        sendResponse(0, 4'h5, 64'hBAD, 64'hBAD);
        checkOutput("t043_no_rsp", core_rsp_val, 2'b00);
        checkOutput("t043_stray", stray_rsp_err, 1'b1);
        tick(3);
        checkOutput("t043_stray_sticky", stray_rsp_err, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("t043_stray_reset", stray_rsp_err, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Both threads requesting from reset alternate grants.
        applyStimulus(0, 1'b1, 5'h01, 4'h0, 3'd3, 40'h100, 64'hA0, 1'b0);
        applyStimulus(1, 1'b1, 5'h01, 4'h0, 3'd3, 40'h200, 64'hB0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            issueAndAck(tid, rdy);
            order[r] = tid;
            sendResponse(tid, 4'h1, 64'(r), 64'h0);
            checkOutput("t041_rsp_onehot", core_rsp_val, N'(1) << tid);
        end
        coreReqVal = '0;
        for (int r = 0; r < 4; r++) checkOutput("t041_grant_order", order[r], r % 2);
        tick(2);

        // Ack and response for the same thread in one cycle: the response is stray.
        applyStimulus(0, 1'b1, 5'h06, 4'h2, 3'd0, 40'h300, 64'hC0, 1'b0);
        tick(1);
        coreReqVal[0] = 1'b0;
        l15Ack = 1'b1;
        l15Val = 1'b1; l15Tid = 1'b0; l15Rtype = 4'h7; l15Data0 = 64'hEE; l15Data1 = 64'hFF;
        tick(1);
        l15Ack = 1'b0;
        l15Val = 1'b0;
        checkOutput("t018_no_rsp", core_rsp_val, 2'b00);
        checkOutput("t018_stray", stray_rsp_err, 1'b1);
        sendResponse(0, 4'h8, 64'h123, 64'h456);
        checkOutput("t018_still_outstanding", core_rsp_val, 2'b01);

        // Reset while a request is on the channel.
        applyStimulus(1, 1'b1, 5'h01, 4'h0, 3'd3, 40'h400, 64'hD0, 1'b0);
        tick(2);
        checkOutput("t044_issuing", transducer_l15_val, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("t044_val_forced", transducer_l15_val, 1'b0);
        coreReqVal = '0;
        tick(2);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            checkOutput("t044_no_rdy", core_req_rdy, 2'b00);
            checkOutput("t044_no_val", transducer_l15_val, 1'b0);
        end

        // Watchdog on thread 0 with no response.
        applyStimulus(0, 1'b1, 5'h01, 4'h0, 3'd3, 40'h500, 64'hE0, 1'b0);
        issueAndAck(tid, rdy);
        coreReqVal = '0;
        tick(10);
        checkOutput("t045_before_limit", timeout_err, 2'b00);
        tick(10);
`ifdef TILE_CORE_IF_MT_TIMEOUT_EN
        expTo = 2'b01;
`else
        expTo = 2'b00;
`endif
        checkOutput("t045_after_limit", timeout_err, expTo);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
